top_level_pixel_filters: RTL and testbench
==========================================

Name: top_level_pixel_filters

Overview:
- Per-pixel brightness filter on an 8-bit greyscale stream with valid/ready handshakes on both sides.
- Maps a heart-rate estimate (BPM_estimate) to a brightness level.
- Brightness is then used either as a pixel threshold or blended additively with each pixel.
- Sits between the pixel source and the display/output pipeline; one pixel per clock when not stalled.

Parameters:
- BPM_MIN, 40: BPM at or below which brightness is 0.
- BPM_MAX, 200: BPM at or above which brightness is 255.
- SMOOTH_SHIFT, 2: IIR shift used only when the optional feature is compiled in.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  synchronous, active-low reset.
- pix_in  input  8  input pixel.
- valid_in  input  1  pix_in valid this cycle.
- module_ready  output  1  block can accept a pixel this cycle.
- filter_enable  input  1  1 = apply filter; 0 = pass pix_in through unchanged.
- filter_mode  input  1  0 = threshold, 1 = additive average.
- BPM_estimate  input  8  unsigned heart-rate estimate.
- pix_out  output  8  filtered pixel.
- valid_out  output  1  pix_out valid.
- output_ready  input  1  downstream accepts pix_out this cycle.
- brightness  output  8  current brightness register.

Behaviour:
- Reset (reset==0 at a clk edge): pix_out=0, valid_out=0, brightness=0. module_ready is forced 0 while reset is low. Any in-flight pixel is discarded.
- Brightness target, combinational, unsigned:
  - 0 if BPM_estimate <= BPM_MIN.
  - 255 if BPM_estimate >= BPM_MAX.
  - Otherwise floor((BPM_estimate-BPM_MIN)*255/(BPM_MAX-BPM_MIN)), using 16-bit intermediate and constant divisor.
- Brightness register is loaded with the target every cycle, independent of the handshake. Latency from a BPM change to brightness is 1 cycle.
- module_ready = !valid_out || output_ready (combinational, when not in reset).
- Accept: valid_in && module_ready at a clk edge loads pix_out and sets valid_out=1 on that edge. Latency is 1 cycle.
- Filter uses the brightness register value present in the accept cycle:
  - filter_enable=0: pix_out = pix_in.
  - filter_mode=0: pix_out = pix_in if pix_in >= brightness, else 0.
  - filter_mode=1: pix_out = (pix_in + brightness) >> 1, using a 9-bit sum, floor; result never exceeds 255.
- Drain: output_ready && !(valid_in && module_ready) clears valid_out on the next edge.
- Accept and drain in the same cycle: new pixel replaces old and valid_out stays 1 (full throughput).
- Stall: valid_out=1 && output_ready=0 means pix_out and valid_out hold stable and module_ready=0. valid_in is ignored.
- filter_mode, filter_enable and BPM_estimate may change on any cycle. They take effect for pixels accepted from that cycle onward; already-registered pix_out is unaffected.
- pix_in is don't-care when valid_in=0.

Optional Feature:
- Macro BRIGHTNESS_SMOOTH_EN.
- Defined: brightness register follows the target through an IIR: brightness <= brightness + ((target - brightness) >>> SMOOTH_SHIFT). Use a signed 10-bit difference, arithmetic shift and result clamped to 0..255. If the shifted step is 0 and target != brightness, step by ±1 so the register converges exactly.
- Not defined: brightness <= target every cycle, as described in Behaviour.

Test Plan:
- Mapping: BPM_estimate = 200, 120, 56, 40, 30 held ≥2 cycles -> brightness = 255, 127, 25, 0, 0 (feature off).
- Threshold, filter_mode=0, BPM=120 (brightness 127): pix_in 155, 127, 105 -> pix_out 155, 127, 0, each 1 cycle after accept.
- Additive, filter_mode=1, BPM=200 (brightness 255): pix_in 255, 5 -> 255, 130; BPM=56 (brightness 25), pix_in 105 -> 65.
- Pass-through and back-to-back: filter_enable=0, 10 consecutive pixels 255,230,...,30 with output_ready=1 -> identical values, valid_out continuous, module_ready always 1.
- Backpressure: valid_out=1, drop output_ready for 3 cycles while valid_in=1 -> module_ready=0, pix_out/valid_out frozen, no pixel lost or duplicated. On release, the next pixel is accepted the same cycle.
- Reset mid-stream: assert reset=0 for one edge with valid_out=1 -> valid_out=0, pix_out=0, brightness=0. With the smoothing macro on, a BPM step 40->200 makes brightness rise monotonically to exactly 255.

Source files
------------

// File: rtl/top_level_pixel_filters_if.sv
// Pixel stream and control bundle for top_level_pixel_filters.
// The filter takes the slave modport; the pixel source/sink side takes master.
interface top_level_pixel_filters_if;
  logic [7:0] pix_in;
  logic       valid_in;
  logic       module_ready;
  logic       filter_enable;
  logic       filter_mode;
  logic [7:0] BPM_estimate;
  logic [7:0] pix_out;
  logic       valid_out;
  logic       output_ready;
  logic [7:0] brightness;

  modport master (
    output pix_in, valid_in, filter_enable, filter_mode, BPM_estimate, output_ready,
    input  module_ready, pix_out, valid_out, brightness
  );

  modport slave (
    input  pix_in, valid_in, filter_enable, filter_mode, BPM_estimate, output_ready,
    output module_ready, pix_out, valid_out, brightness
  );
endinterface

// File: rtl/top_level_pixel_filters.sv
// BPM-driven brightness filter on an 8-bit greyscale stream (threshold or additive blend).
// Optional macro BRIGHTNESS_SMOOTH_EN: brightness follows its target through an IIR.
module top_level_pixel_filters #(
  parameter int BPM_MIN      = 40,
  parameter int BPM_MAX      = 200,
  parameter int SMOOTH_SHIFT = 2
) (
  input logic                          clk,
  input logic                          reset,
  top_level_pixel_filters_if.slave     bus
);
  localparam logic [15:0] BPM_SPAN = 16'(BPM_MAX - BPM_MIN);

  // Reject shift values that would make the IIR step meaningless.
  generate
    if (SMOOTH_SHIFT < 1 || SMOOTH_SHIFT > 9) begin : g_bad_smooth_shift
      $error("SMOOTH_SHIFT must be in 1..9");
    end
  endgenerate

  logic [7:0]  pix_out_reg, pix_out_next;
  logic        valid_out_reg, valid_out_next;
  logic [7:0]  brightness_reg, brightness_next;
  logic [7:0]  target;
  logic [15:0] bpm_offset;
  logic [15:0] bpm_scaled;
  logic [8:0]  blend_sum;
  logic [7:0]  filtered;
  logic        ready;
  logic        accept;

  always_comb begin
    bpm_offset = 16'(bus.BPM_estimate) - 16'(BPM_MIN);
    bpm_scaled = bpm_offset * 16'd255;
    if (int'(bus.BPM_estimate) <= BPM_MIN) begin
      target = 8'd0;
    end else if (int'(bus.BPM_estimate) >= BPM_MAX) begin
      target = 8'd255;
    end else begin
      target = 8'(bpm_scaled / BPM_SPAN);
    end
  end

`ifdef BRIGHTNESS_SMOOTH_EN
  logic signed [9:0] smooth_diff;
  logic signed [9:0] smooth_step;
  logic signed [9:0] smooth_sum;

  always_comb begin
    smooth_diff = $signed({2'b00, target}) - $signed({2'b00, brightness_reg});
    smooth_step = smooth_diff >>> SMOOTH_SHIFT;
    // A zero step near the target would stall short of it; nudge by one.
    if (smooth_step == 10'sd0 && smooth_diff != 10'sd0) begin
      smooth_step = smooth_diff[9] ? -10'sd1 : 10'sd1;
    end
    smooth_sum = $signed({2'b00, brightness_reg}) + smooth_step;
    if (smooth_sum < 10'sd0) begin
      brightness_next = 8'd0;
    end else if (smooth_sum > 10'sd255) begin
      brightness_next = 8'd255;
    end else begin
      brightness_next = smooth_sum[7:0];
    end
  end
`else
  always_comb begin
    brightness_next = target;
  end
`endif

  always_comb begin
    blend_sum = {1'b0, bus.pix_in} + {1'b0, brightness_reg};
    if (!bus.filter_enable) begin
      filtered = bus.pix_in;
    end else if (!bus.filter_mode) begin
      filtered = (bus.pix_in >= brightness_reg) ? bus.pix_in : 8'd0;
    end else begin
      filtered = 8'(blend_sum >> 1);
    end
  end

  assign ready  = reset && (!valid_out_reg || bus.output_ready);
  assign accept = bus.valid_in && ready;

  always_comb begin
    pix_out_next   = pix_out_reg;
    valid_out_next = valid_out_reg;
    if (accept) begin
      pix_out_next   = filtered;
      valid_out_next = 1'b1;
    end else if (bus.output_ready) begin
      valid_out_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pix_out_reg    <= 8'd0;
      valid_out_reg  <= 1'b0;
      brightness_reg <= 8'd0;
    end else begin
      pix_out_reg    <= pix_out_next;
      valid_out_reg  <= valid_out_next;
      brightness_reg <= brightness_next;
    end
  end

  assign bus.module_ready = ready;
  assign bus.pix_out      = pix_out_reg;
  assign bus.valid_out    = valid_out_reg;
  assign bus.brightness   = brightness_reg;
endmodule

// File: tb/tb_top_level_pixel_filters.sv
// Directed-vector bench for top_level_pixel_filters; expected values are hand-computed.
module tb_top_level_pixel_filters;
  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  top_level_pixel_filters_if bus ();

  top_level_pixel_filters #(
    .BPM_MIN      (40),
    .BPM_MAX      (200),
    .SMOOTH_SHIFT (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: %0d", tag, got);
    end
  endtask

  // Advance one clock; outputs are then read 1 time unit after the edge.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  int bpm_vec [5] = '{200, 120, 56, 40, 30};
  int bri_vec [5] = '{255, 127, 25, 0, 0};
  int thr_in  [3] = '{155, 127, 105};
  int thr_exp [3] = '{155, 127, 0};
  int add_bpm [3] = '{200, 200, 56};
  int add_in  [3] = '{255, 5, 105};
  int add_exp [3] = '{255, 130, 65};

  initial begin
    tests_run           = 0;
    tests_failed        = 0;
    reset               = 1'b0;
    bus.pix_in          = 8'd0;
    bus.valid_in        = 1'b0;
    bus.filter_enable   = 1'b0;
    bus.filter_mode     = 1'b0;
    bus.BPM_estimate    = 8'd200;
    bus.output_ready    = 1'b1;
    step(2);
    check("reset_valid_out", int'(bus.valid_out), 0);
    check("reset_pix_out", int'(bus.pix_out), 0);
    check("reset_brightness", int'(bus.brightness), 0);
    check("reset_module_ready", int'(bus.module_ready), 0);
    reset = 1'b1;

    for (int i = 0; i < 5; i++) begin
      bus.BPM_estimate = 8'(bpm_vec[i]);
      step(2);
      check($sformatf("map_bpm%0d", bpm_vec[i]), int'(bus.brightness), bri_vec[i]);
    end

    bus.filter_enable = 1'b1;
    bus.filter_mode   = 1'b0;
    bus.BPM_estimate  = 8'd120;
    step(2);
    for (int i = 0; i < 3; i++) begin
      bus.pix_in   = 8'(thr_in[i]);
      bus.valid_in = 1'b1;
      step(1);
      check($sformatf("thr_pix%0d", thr_in[i]), int'(bus.pix_out), thr_exp[i]);
      check($sformatf("thr_valid%0d", thr_in[i]), int'(bus.valid_out), 1);
    end
    bus.valid_in = 1'b0;
    step(1);
    check("thr_drain_valid", int'(bus.valid_out), 0);

    bus.filter_mode = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.valid_in     = 1'b0;
      bus.BPM_estimate = 8'(add_bpm[i]);
      step(2);
      bus.pix_in   = 8'(add_in[i]);
      bus.valid_in = 1'b1;
      step(1);
      check($sformatf("add_pix%0d", add_in[i]), int'(bus.pix_out), add_exp[i]);
    end
    bus.valid_in = 1'b0;
    step(1);

    bus.filter_enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.pix_in   = 8'(255 - 25 * i);
      bus.valid_in = 1'b1;
      check($sformatf("pass_ready%0d", i), int'(bus.module_ready), 1);
      step(1);
      check($sformatf("pass_pix%0d", i), int'(bus.pix_out), 255 - 25 * i);
      check($sformatf("pass_valid%0d", i), int'(bus.valid_out), 1);
    end

    bus.pix_in = 8'd11;
    step(1);
    check("bp_first_pix", int'(bus.pix_out), 11);
    bus.output_ready = 1'b0;
    bus.pix_in       = 8'd22;
    #1;
    check("bp_ready_low", int'(bus.module_ready), 0);
    for (int i = 0; i < 3; i++) begin
      step(1);
      check($sformatf("bp_hold_pix%0d", i), int'(bus.pix_out), 11);
      check($sformatf("bp_hold_valid%0d", i), int'(bus.valid_out), 1);
      check($sformatf("bp_hold_ready%0d", i), int'(bus.module_ready), 0);
    end
    bus.output_ready = 1'b1;
    #1;
    check("bp_release_ready", int'(bus.module_ready), 1);
    step(1);
    check("bp_next_pix", int'(bus.pix_out), 22);
    check("bp_next_valid", int'(bus.valid_out), 1);
    bus.valid_in = 1'b0;
    step(1);
    check("bp_drain_valid", int'(bus.valid_out), 0);
    check("bp_drain_pix", int'(bus.pix_out), 22);

    bus.BPM_estimate = 8'd200;
    bus.pix_in       = 8'd77;
    bus.valid_in     = 1'b1;
    step(2);
    check("rst_pre_valid", int'(bus.valid_out), 1);
    check("rst_pre_pix", int'(bus.pix_out), 77);
    reset        = 1'b0;
    bus.valid_in = 1'b0;
    #1;
    check("rst_ready_low", int'(bus.module_ready), 0);
    step(1);
    check("rst_valid_out", int'(bus.valid_out), 0);
    check("rst_pix_out", int'(bus.pix_out), 0);
    check("rst_brightness", int'(bus.brightness), 0);
    reset            = 1'b1;
    bus.BPM_estimate = 8'd40;
    step(2);

`ifdef BRIGHTNESS_SMOOTH_EN
    begin
      int prev;
      bit mono;
      prev = int'(bus.brightness);
      mono = 1'b1;
      bus.BPM_estimate = 8'd200;
      for (int i = 0; i < 40; i++) begin
        step(1);
        if (int'(bus.brightness) < prev) mono = 1'b0;
        prev = int'(bus.brightness);
      end
      check("smooth_monotonic", int'(mono), 1);
      check("smooth_final", int'(bus.brightness), 255);
    end
`else
    check("step_low_brightness", int'(bus.brightness), 0);
    bus.BPM_estimate = 8'd200;
    step(1);
    check("step_one_cycle", int'(bus.brightness), 255);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
